// File: rtl/wakeup_broadcast.sv
// ---------------------------------------------------------------------------
// wakeup_broadcast
//
// Completion side of the scheduler wakeup matrix. Each reservation-station
// entry that select issues is timed by its functional-unit latency. When the
// op is one cycle from completing, a one-cycle wakeup bit is broadcast on
// ready_mask. After completion the entry is freed through a single retire
// port, one entry per cycle, lowest index first.
//
// Handshake: there is no valid/ready handshake. grant_valid is a single-cycle
// strobe that is sampled on every rising edge, and there is no backpressure.
// A grant to an entry that is not IDLE is dropped and sets err_busy.
// ready_mask and retire_valid are one-cycle pulses that the consumer must
// take in the cycle they are asserted.
//
// Ports:
//   clk          in   clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   grant_valid  in   select issued an op this cycle
//   grant        in   RS entry issued
//   grant_fu     in   FU pipe executing the op
//   grant_lat    in   execution latency (0 -> 1, >MAX_LAT -> MAX_LAT)
//   flush        in   discard all in-flight ops
//   ready_mask   out  wakeup broadcast, bit = fu*RS_ENTRIES + entry
//   retire_entry out  entry being freed (holds its value when idle)
//   retire_valid out  retire_entry is valid this cycle
//   err_busy     out  sticky: a grant hit an entry already in flight
// ---------------------------------------------------------------------------
module wakeup_broadcast #(
  parameter int RS_ENTRIES = 8,
  parameter int NUM_FUS    = 2,
  parameter int MAX_LAT    = 4,
  localparam int EW = $clog2(RS_ENTRIES),
  localparam int FW = $clog2(NUM_FUS),
  localparam int LW = $clog2(MAX_LAT + 1),
  localparam int MW = RS_ENTRIES * NUM_FUS
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          grant_valid,
  input  logic [EW-1:0] grant,
  input  logic [FW-1:0] grant_fu,
  input  logic [LW-1:0] grant_lat,
  input  logic          flush,
  output logic [MW-1:0] ready_mask,
  output logic [EW-1:0] retire_entry,
  output logic          retire_valid,
  output logic          err_busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
  } entry_state_t;

  // Per-entry state. cnt_q holds the number of rising edges left until the
  // entry leaves EXEC; it moves to DONE on the edge where cnt_q == 1.
  entry_state_t  state_q [RS_ENTRIES];
  entry_state_t  state_d [RS_ENTRIES];
  logic [LW-1:0] cnt_q   [RS_ENTRIES];
  logic [LW-1:0] cnt_d   [RS_ENTRIES];
  logic [FW-1:0] fu_q    [RS_ENTRIES];
  logic [FW-1:0] fu_d    [RS_ENTRIES];

  logic [MW-1:0] ready_d;
  logic [EW-1:0] retire_entry_d;
  logic          retire_valid_d;
  logic          err_busy_d;
  logic [LW-1:0] eff_lat;
  logic          grant_busy;

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    fu_d           = fu_q;
    ready_d        = '0;
    retire_entry_d = retire_entry;
    retire_valid_d = 1'b0;
    err_busy_d     = err_busy;

    if (grant_lat == '0) begin
      eff_lat = LW'(1);
    end else if (grant_lat > LW'(MAX_LAT)) begin
      eff_lat = LW'(MAX_LAT);
    end else begin
      eff_lat = grant_lat;
    end

    // The entry currently on the retire port is still DONE, so a grant to it
    // in the same cycle is counted as busy.
    grant_busy = grant_valid && (state_q[grant] != S_IDLE);

    // The entry presented on the retire port this cycle is freed at this edge.
    if (retire_valid) begin
      state_d[retire_entry] = S_IDLE;
    end

    for (int e = 0; e < RS_ENTRIES; e++) begin
      if (state_q[e] == S_EXEC) begin
        if (cnt_q[e] == LW'(1)) begin
          state_d[e] = S_DONE;
        end else begin
          cnt_d[e] = cnt_q[e] - LW'(1);
        end
      end
    end

    if (grant_valid && !grant_busy) begin
      state_d[grant] = S_EXEC;
      cnt_d[grant]   = eff_lat;
      fu_d[grant]    = grant_fu;
    end

    if (flush) begin
      for (int e = 0; e < RS_ENTRIES; e++) begin
        state_d[e] = S_IDLE;
      end
    end else if (grant_busy) begin
      err_busy_d = 1'b1;
    end

    // Broadcast in the cycle before the entry reaches DONE: that is exactly
    // the entries that will be in EXEC with one edge left after this edge.
    // An L=1 grant lands here directly with cnt_d == 1.
    for (int f = 0; f < NUM_FUS; f++) begin
      for (int e = 0; e < RS_ENTRIES; e++) begin
        ready_d[f*RS_ENTRIES + e] = (state_d[e] == S_EXEC) &&
                                    (cnt_d[e] == LW'(1)) &&
                                    (fu_d[e] == FW'(f));
      end
    end

    // Present the lowest-index DONE entry. A descending scan leaves the
    // lowest index as the final assignment.
    for (int e = RS_ENTRIES - 1; e >= 0; e--) begin
      if (state_d[e] == S_DONE) begin
        retire_valid_d = 1'b1;
        retire_entry_d = EW'(e);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int e = 0; e < RS_ENTRIES; e++) begin
        state_q[e] <= S_IDLE;
        cnt_q[e]   <= '0;
        fu_q[e]    <= '0;
      end
      ready_mask   <= '0;
      retire_entry <= '0;
      retire_valid <= 1'b0;
      err_busy     <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      fu_q         <= fu_d;
      ready_mask   <= ready_d;
      retire_entry <= retire_entry_d;
      retire_valid <= retire_valid_d;
      err_busy     <= err_busy_d;
    end
  end

endmodule

// File: doc/wakeup_broadcast.md
Name: wakeup_broadcast

Overview:
- Completion-side partner of the scheduler wakeup matrix.
- Accepts grants from select and times each issued op by its functional-unit latency.
- Drives the one-cycle ready_mask broadcast that clears dependents in the dependency matrix.
- Sequences the single retire_entry/retire_valid port that frees the op's RS entry.

Parameters:
- RS_ENTRIES, 8: number of reservation-station entries tracked.
- NUM_FUS, 2: number of functional-unit pipes (minimum 2).
- MAX_LAT, 4: maximum execution latency in cycles (minimum 1).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset; asynchronous assert, active-low.
- grant_valid  in  1  select issued an op this cycle.
- grant  in  $clog2(RS_ENTRIES)  RS entry issued.
- grant_fu  in  $clog2(NUM_FUS)  FU pipe executing the op.
- grant_lat  in  $clog2(MAX_LAT+1)  execution latency in cycles.
- flush  in  1  discard all in-flight ops.
- ready_mask  out  RS_ENTRIES*NUM_FUS  one-hot-per-op wakeup broadcast. Bit index is grant_fu*RS_ENTRIES+grant.
- retire_entry  out  $clog2(RS_ENTRIES)  entry being freed.
- retire_valid  out  1  retire_entry is valid this cycle.
- err_busy  out  1  sticky flag: a grant targeted an entry already in flight.

Behaviour:
- Per-entry state is IDLE, EXEC or DONE, plus a latency counter and the stored fu index.
- All state and outputs are registered.
- Reset (rst_n low, asynchronous):
  - every entry goes to IDLE;
  - ready_mask = 0, retire_valid = 0, retire_entry = 0, err_busy = 0.
- Reset mid-flight drops all ops silently. No broadcast or retire follows deassertion until new grants arrive.
- Grant:
  - sampled at edge E0 when grant_valid = 1 and the entry is IDLE;
  - entry moves to EXEC and stores fu and the effective latency L.
- Effective latency:
  - grant_lat = 0 is treated as L = 1;
  - grant_lat > MAX_LAT is clamped to L = MAX_LAT.
- Broadcast:
  - ready_mask bit (fu*RS_ENTRIES+entry) is high for exactly the one cycle following edge E0+L−1;
  - L = 1 therefore broadcasts in the cycle immediately after the grant edge;
  - at edge E0+L the entry moves EXEC → DONE.
- Multiple ops may broadcast in the same cycle. Their bits are ORed into ready_mask, and no broadcast is ever lost.
- Retire:
  - each cycle, the lowest-index DONE entry is selected;
  - it is presented on retire_entry with retire_valid high for one cycle, then the entry returns to IDLE;
  - earliest retire cycle is the cycle after the broadcast cycle;
  - multiple DONE entries retire one per cycle in ascending index order;
  - retire_entry holds its last value when retire_valid = 0.
- Busy grant: a grant to an entry in EXEC or DONE is ignored (no state change) and err_busy sets. err_busy clears only on reset.
- Simultaneous grant and retire of the same entry in one cycle:
  - the retire completes;
  - the grant is treated as a busy grant (ignored, err_busy set).
- Grant and other entries' broadcast/retire in the same cycle are independent and all take effect.
- flush:
  - at the edge where flush = 1, all entries return to IDLE;
  - next cycle ready_mask = 0 and retire_valid = 0;
  - a grant sampled in the flush cycle is dropped.
- At most one grant per cycle. There is no backpressure; every in-flight op has a dedicated entry slot, so capacity cannot overflow.

Test Plan:
- Single op, L = 1: RS_ENTRIES=8, NUM_FUS=2; grant=3, fu=1, lat=1 at edge 0.
  - ready_mask = 0x0800 in cycle 1 only;
  - retire_valid = 1 with retire_entry = 3 in cycle 2.
- Latency ordering and clamp: grant entry 0, fu 0, lat 4 at edge 0; grant entry 5, fu 1, lat 1 at edge 1.
  - bit 13 high in cycle 2, then retire of entry 5 in cycle 3;
  - bit 0 high in cycle 4, then retire of entry 0 in cycle 5;
  - repeat with lat = 7: behaves as lat 4 (MAX_LAT);
  - repeat with lat = 0: behaves as lat 1.
- Collision: entries 6 (lat 2, granted edge 0) and 2 (lat 1, granted edge 1), both fu 0.
  - ready_mask = 0x0044 in cycle 2;
  - retires: entry 2 in cycle 3, entry 6 in cycle 4.
- Busy grant: grant entry 4 (lat 3) at edge 0; grant entry 4 again at edge 1.
  - err_busy high from cycle 2 onward;
  - exactly one broadcast (cycle 3) and one retire (cycle 4) for entry 4.
- Flush: three ops in flight, assert flush for one cycle along with a new grant.
  - no ready_mask bits and no retire_valid afterwards;
  - a subsequent grant to any flushed entry is accepted with err_busy still 0.
- Async reset mid-flight: drop rst_n between clock edges while ops are in EXEC.
  - all outputs go to 0 immediately, without waiting for a clock edge;
  - after release, fresh grants broadcast with normal timing.
